// File: rtl/ifft_pkg.sv
// ifft_pkg: shared config layout, state encoding and core config packing for the IFFT frame controller
package ifft_pkg;
  localparam int MIN_LOG2N = 3;
  localparam int NFFT_LSB = 0;
  localparam int CP_LSB = 8;
  typedef enum logic [1:0] {CFG_SEND, RUN, PEND} cfg_state_t;
  function automatic logic [23:0] pack_cfg(input logic [4:0] log2n, input logic [15:0] cp,
                                           input int cp_w, input logic inverse, input logic [5:0] scale);
    logic [23:0] mask;
    mask = (24'd1 << cp_w) - 24'd1;
    return (24'(log2n) << NFFT_LSB) | ((24'(cp) & mask) << CP_LSB) |
           (24'(!inverse) << (CP_LSB + cp_w)) | (24'(scale) << (CP_LSB + cp_w + 1));
  endfunction
endpackage

// File: rtl/ifft_cfg_fifo.sv
// ifft_cfg_fifo: 2-deep FIFO of per-frame {log2n, cp_len} used to size output frames
module ifft_cfg_fifo #(
  parameter int W = 11
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic wr_ptr, rd_ptr, do_push, do_pop;
  logic [1:0] cnt;
  assign do_pop = pop & (cnt != 2'd0);
  assign do_push = push & ((cnt != 2'd2) | do_pop);
  assign dout = mem[rd_ptr];
  assign empty = cnt == 2'd0;
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/ifft_frame_ctrl.sv
// ifft_frame_ctrl: config loader, input tlast regeneration and framing checks around a vendor FFT core
module ifft_frame_ctrl
  import ifft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MAX_LOG2N = 6,
  parameter int DEF_LOG2N = 3,
  parameter int DEF_CP = 4,
  parameter logic [5:0] DEF_SCALE = 6'b000100,
  parameter int CNT_W = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [4:0]            cfg_log2n,
  input  logic [MAX_LOG2N-1:0]  cfg_cp_len,
  input  logic                  cfg_inverse,
  input  logic [5:0]            cfg_scale,
  input  logic                  cfg_req,
  output logic                  cfg_busy,
  output logic                  cfg_err,
  input  logic [2*DATA_W-1:0]   s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  input  logic                  s_axis_data_tlast,
  output logic                  s_axis_data_tready,
  output logic [23:0]           core_cfg_tdata,
  output logic                  core_cfg_tvalid,
  input  logic                  core_cfg_tready,
  output logic [2*DATA_W-1:0]   core_in_tdata,
  output logic                  core_in_tvalid,
  output logic                  core_in_tlast,
  input  logic                  core_in_tready,
  input  logic [2*DATA_W-1:0]   core_out_tdata,
  input  logic [7:0]            core_out_tuser,
  input  logic                  core_out_tvalid,
  input  logic                  core_out_tlast,
  output logic                  core_out_tready,
  output logic [2*DATA_W-1:0]   m_axis_data_tdata,
  output logic [7:0]            m_axis_data_tuser,
  output logic                  m_axis_data_tvalid,
  output logic                  m_axis_data_tlast,
  input  logic                  m_axis_data_tready,
  output logic [DATA_W-1:0]     m_axis_real_unsigned,
  output logic                  err_early,
  output logic                  err_late,
  output logic                  err_out_len,
  output logic [CNT_W-1:0]      frames_out
);
  cfg_state_t state, next_state;
  logic [4:0] act_log2n, pend_log2n, f_log2n, q_log2n;
  logic [MAX_LOG2N-1:0] act_cp, pend_cp, f_cp, q_cp, in_cnt, n_m1;
  logic act_inv, pend_inv, req_legal, req_ok, req_bad, gate, in_hs, last_beat, out_hs, out_end, f_empty;
  logic [5:0] act_scale, pend_scale;
  logic [MAX_LOG2N:0] out_cnt;
  assign req_legal = cfg_log2n >= 5'(MIN_LOG2N) && cfg_log2n <= 5'(MAX_LOG2N) &&
                     32'(cfg_cp_len) < (32'd1 << cfg_log2n);
  assign req_ok = state == RUN && cfg_req && req_legal;
  assign req_bad = state == RUN && cfg_req && !req_legal;
  assign n_m1 = MAX_LOG2N'((32'd1 << act_log2n) - 32'd1);
  assign last_beat = in_cnt == n_m1;
  assign in_hs = s_axis_data_tvalid & s_axis_data_tready;
  always_ff @(posedge aclk) state <= areset ? CFG_SEND : next_state;
  // a pending config is applied only once the current input frame has fully drained
  always_comb begin
    next_state = state == CFG_SEND ? (core_cfg_tready ? RUN : CFG_SEND) :
                 state == RUN      ? (req_ok ? PEND : RUN) :
                 (in_cnt == '0 && !in_hs) ? CFG_SEND : PEND;
  end
  always_comb begin
    core_cfg_tvalid = state == CFG_SEND;
    cfg_busy = state != RUN;
    gate = state == RUN || (state == PEND && in_cnt != '0);
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      act_log2n <= 5'(DEF_LOG2N);
      act_cp <= MAX_LOG2N'(DEF_CP);
      act_inv <= 1'b1;
      act_scale <= DEF_SCALE;
      pend_log2n <= '0;
      pend_cp <= '0;
      pend_inv <= 1'b0;
      pend_scale <= '0;
    end else begin
      if (req_ok) begin
        pend_log2n <= cfg_log2n;
        pend_cp <= cfg_cp_len;
        pend_inv <= cfg_inverse;
        pend_scale <= cfg_scale;
      end
      if (state == PEND && next_state == CFG_SEND) begin
        act_log2n <= pend_log2n;
        act_cp <= pend_cp;
        act_inv <= pend_inv;
        act_scale <= pend_scale;
      end
    end
  end
  assign core_cfg_tdata = pack_cfg(act_log2n, 16'(act_cp), MAX_LOG2N, act_inv, act_scale);
  assign s_axis_data_tready = core_in_tready & gate;
  assign core_in_tvalid = s_axis_data_tvalid & gate;
  assign core_in_tdata = s_axis_data_tdata;
  assign core_in_tlast = last_beat;
  assign core_out_tready = m_axis_data_tready;
  assign m_axis_data_tdata = core_out_tdata;
  assign m_axis_data_tuser = core_out_tuser;
  assign m_axis_data_tvalid = core_out_tvalid;
  assign m_axis_data_tlast = core_out_tlast;
  assign m_axis_real_unsigned = {~core_out_tdata[2*DATA_W-1], core_out_tdata[2*DATA_W-2:DATA_W]};
  assign out_hs = core_out_tvalid & m_axis_data_tready;
  // output frames are sized by the config their input frame was accepted under
  ifft_cfg_fifo #(.W(5 + MAX_LOG2N)) u_fifo (
    .aclk(aclk),
    .areset(areset),
    .push(in_hs & last_beat),
    .din({act_log2n, act_cp}),
    .pop(out_hs & core_out_tlast),
    .dout({q_log2n, q_cp}),
    .empty(f_empty)
  );
  assign f_log2n = f_empty ? act_log2n : q_log2n;
  assign f_cp = f_empty ? act_cp : q_cp;
  assign out_end = 32'(out_cnt) == (32'd1 << f_log2n) + 32'(f_cp) - 32'd1;
  always_ff @(posedge aclk) begin
    if (areset) begin
      in_cnt <= '0;
      out_cnt <= '0;
      frames_out <= '0;
      cfg_err <= 1'b0;
      err_early <= 1'b0;
      err_late <= 1'b0;
      err_out_len <= 1'b0;
    end else begin
      cfg_err <= req_bad;
      err_early <= in_hs & s_axis_data_tlast & !last_beat;
      err_late <= in_hs & !s_axis_data_tlast & last_beat;
      err_out_len <= out_hs & (core_out_tlast ? !out_end : out_end);
      if (in_hs) in_cnt <= last_beat ? '0 : in_cnt + MAX_LOG2N'(1);
      if (out_hs) out_cnt <= (core_out_tlast | out_end) ? '0 : out_cnt + (MAX_LOG2N + 1)'(1);
      if (out_hs & core_out_tlast) frames_out <= frames_out + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ifft_frame_ctrl.sv
// tb_ifft_frame_ctrl: scoreboard bench with directed frames for ifft_frame_ctrl
module tb_ifft_frame_ctrl;
  logic aclk = 1'b0, areset = 1'b1;
  logic [4:0] cfg_log2n = '0;
  logic [5:0] cfg_cp_len = '0, cfg_scale = '0;
  logic cfg_inverse = 1'b0, cfg_req = 1'b0, cfg_busy, cfg_err;
  logic [31:0] s_axis_data_tdata = '0, core_in_tdata, core_out_tdata = '0, m_axis_data_tdata;
  logic s_axis_data_tvalid = 1'b0, s_axis_data_tlast = 1'b0, s_axis_data_tready;
  logic [23:0] core_cfg_tdata;
  logic core_cfg_tvalid, core_cfg_tready = 1'b0;
  logic core_in_tvalid, core_in_tlast, core_in_tready = 1'b1;
  logic [7:0] core_out_tuser = '0, m_axis_data_tuser;
  logic core_out_tvalid = 1'b0, core_out_tlast = 1'b0, core_out_tready;
  logic m_axis_data_tvalid, m_axis_data_tlast, m_axis_data_tready = 1'b1;
  logic [15:0] m_axis_real_unsigned;
  logic err_early, err_late, err_out_len;
  logic [15:0] frames_out;
  int n_checks = 0, n_fail = 0;
  logic [32:0] exp_in[$];
  logic [56:0] exp_out[$];
  logic [23:0] exp_cfg[$];
  int exp_err[$];

  ifft_frame_ctrl dut (
    .aclk(aclk), .areset(areset),
    .cfg_log2n(cfg_log2n), .cfg_cp_len(cfg_cp_len), .cfg_inverse(cfg_inverse), .cfg_scale(cfg_scale),
    .cfg_req(cfg_req), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .s_axis_data_tdata(s_axis_data_tdata), .s_axis_data_tvalid(s_axis_data_tvalid),
    .s_axis_data_tlast(s_axis_data_tlast), .s_axis_data_tready(s_axis_data_tready),
    .core_cfg_tdata(core_cfg_tdata), .core_cfg_tvalid(core_cfg_tvalid), .core_cfg_tready(core_cfg_tready),
    .core_in_tdata(core_in_tdata), .core_in_tvalid(core_in_tvalid), .core_in_tlast(core_in_tlast),
    .core_in_tready(core_in_tready),
    .core_out_tdata(core_out_tdata), .core_out_tuser(core_out_tuser), .core_out_tvalid(core_out_tvalid),
    .core_out_tlast(core_out_tlast), .core_out_tready(core_out_tready),
    .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tuser(m_axis_data_tuser),
    .m_axis_data_tvalid(m_axis_data_tvalid), .m_axis_data_tlast(m_axis_data_tlast),
    .m_axis_data_tready(m_axis_data_tready), .m_axis_real_unsigned(m_axis_real_unsigned),
    .err_early(err_early), .err_late(err_late), .err_out_len(err_out_len), .frames_out(frames_out)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic err_seen(input int code);
    if (exp_err.size() == 0) unexpected("err_pulse", 64'(code));
    else check("err_kind", 64'(code), 64'(exp_err.pop_front()));
  endtask

  // monitor: compares every DUT output transfer against the queued expectations
  always @(negedge aclk) begin
    if (core_in_tvalid && core_in_tready) begin
      if (exp_in.size() == 0) unexpected("core_in_beat", 64'({core_in_tlast, core_in_tdata}));
      else check("core_in_beat", 64'({core_in_tlast, core_in_tdata}), 64'(exp_in.pop_front()));
    end
    if (m_axis_data_tvalid && m_axis_data_tready) begin
      if (exp_out.size() == 0) unexpected("m_axis_beat", 64'(m_axis_data_tdata));
      else check("m_axis_beat", 64'({m_axis_data_tlast, m_axis_data_tuser, m_axis_real_unsigned, m_axis_data_tdata}),
                 64'(exp_out.pop_front()));
    end
    if (core_cfg_tvalid && core_cfg_tready) begin
      if (exp_cfg.size() == 0) unexpected("core_cfg", 64'(core_cfg_tdata));
      else check("core_cfg", 64'(core_cfg_tdata), 64'(exp_cfg.pop_front()));
    end
    if (err_early) err_seen(0);
    if (err_late) err_seen(1);
    if (err_out_len) err_seen(2);
    if (cfg_err) err_seen(3);
  end

  task automatic send_beat(input logic [31:0] d, input logic l, input logic exp_last);
    int t = 0;
    s_axis_data_tdata = d;
    s_axis_data_tlast = l;
    s_axis_data_tvalid = 1'b1;
    exp_in.push_back({exp_last, d});
    while (!s_axis_data_tready && t < 200) begin
      @(posedge aclk); #1;
      t++;
    end
    if (!s_axis_data_tready) unexpected("s_ready_timeout", 64'(t));
    @(posedge aclk); #1;
    s_axis_data_tvalid = 1'b0;
    s_axis_data_tlast = 1'b0;
  endtask

  task automatic in_frame(input int len, input int n, input int tl_at, input int req_at);
    for (int i = 0; i < len; i++) begin
      if (i == req_at) cfg_req = 1'b1;
      send_beat({16'(i + 100), 16'(i)}, i == tl_at, (i % n) == n - 1);
      cfg_req = 1'b0;
    end
  endtask

  task automatic out_frame(input int len, input int tl_at);
    logic [15:0] r;
    for (int i = 0; i < len; i++) begin
      r = i == 0 ? 16'h8000 : i == 1 ? 16'h7FFF : 16'(i * 257);
      core_out_tdata = {r, 16'(i)};
      core_out_tuser = 8'(i);
      core_out_tlast = i == tl_at;
      core_out_tvalid = 1'b1;
      exp_out.push_back({i == tl_at, 8'(i), 16'(r + 16'h8000), r, 16'(i)});
      @(posedge aclk); #1;
    end
    core_out_tvalid = 1'b0;
    core_out_tlast = 1'b0;
  endtask

  task automatic cfg_try(input logic [4:0] l2, input logic [5:0] cp);
    cfg_log2n = l2;
    cfg_cp_len = cp;
    cfg_req = 1'b1;
    exp_err.push_back(3);
    @(posedge aclk); #1;
    cfg_req = 1'b0;
    check("cfg_err_pulse", 64'(cfg_err), 64'(1));
    check("cfg_busy_after_bad", 64'(cfg_busy), 64'(0));
    @(posedge aclk); #1;
    check("cfg_err_clear", 64'(cfg_err), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    check("rst_cfg_tvalid", 64'(core_cfg_tvalid), 64'(1));
    check("rst_busy", 64'(cfg_busy), 64'(1));
    check("rst_s_ready", 64'(s_axis_data_tready), 64'(0));
    check("rst_frames", 64'(frames_out), 64'(0));
    check("rst_errs", 64'({cfg_err, err_early, err_late, err_out_len}), 64'(0));
    exp_cfg.push_back(24'h020403);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    core_cfg_tready = 1'b1;
    @(posedge aclk); #1;
    check("cfg_tvalid_drop", 64'(core_cfg_tvalid), 64'(0));
    check("cfg_busy_fall", 64'(cfg_busy), 64'(0));
    in_frame(8, 8, 7, -1);
    out_frame(12, 11);
    @(posedge aclk); #1;
    check("frames_1", 64'(frames_out), 64'(1));
    exp_err.push_back(0);
    exp_err.push_back(1);
    in_frame(8, 8, 4, -1);
    out_frame(12, 11);
    @(posedge aclk); #1;
    check("frames_2", 64'(frames_out), 64'(2));
    cfg_log2n = 5'd6;
    cfg_cp_len = 6'd16;
    cfg_inverse = 1'b1;
    cfg_scale = 6'b000100;
    exp_cfg.push_back(24'h021006);
    in_frame(8, 8, 7, 2);
    check("pend_s_ready", 64'(s_axis_data_tready), 64'(0));
    check("pend_busy", 64'(cfg_busy), 64'(1));
    in_frame(64, 64, 63, -1);
    out_frame(12, 11);
    out_frame(80, 79);
    @(posedge aclk); #1;
    check("frames_4", 64'(frames_out), 64'(4));
    cfg_try(5'd7, 6'd0);
    cfg_try(5'd3, 6'd8);
    core_out_tdata = 32'h8000_1234;
    #1 check("real_u_8000", 64'(m_axis_real_unsigned), 64'h0000);
    core_out_tdata = 32'h7FFF_0000;
    #1 check("real_u_7fff", 64'(m_axis_real_unsigned), 64'hFFFF);
    @(posedge aclk); #1;
    for (int i = 0; i < 4; i++) send_beat({16'(i + 100), 16'(i)}, 1'b0, 1'b0);
    exp_cfg.push_back(24'h020403);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    check("mid_rst_s_ready", 64'(s_axis_data_tready), 64'(0));
    check("mid_rst_cfg_tvalid", 64'(core_cfg_tvalid), 64'(1));
    check("mid_rst_frames", 64'(frames_out), 64'(0));
    in_frame(8, 8, 7, -1);
    out_frame(12, 11);
    @(posedge aclk); #1;
    check("frames_after_rst", 64'(frames_out), 64'(1));
    in_frame(8, 8, 7, -1);
    exp_err.push_back(2);
    out_frame(10, 9);
    in_frame(8, 8, 7, -1);
    exp_err.push_back(2);
    out_frame(12, -1);
    repeat (3) @(posedge aclk);
    #1 check("frames_final", 64'(frames_out), 64'(2));
    check("left_in", 64'(exp_in.size()), 64'(0));
    check("left_out", 64'(exp_out.size()), 64'(0));
    check("left_cfg", 64'(exp_cfg.size()), 64'(0));
    check("left_err", 64'(exp_err.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
